// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the register-file access controller:
//               default widths, request opcodes and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default geometry of the single-port register file (16 x 32)
    localparam int DEF_DATA_W = 32;
    localparam int DEF_SEL_W  = 4;

    // Request opcodes carried on req_op
    localparam logic [1:0] OP_READ1 = 2'b00;
    localparam logic [1:0] OP_READ2 = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Controller states; one register-file access per non-idle cycle
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_ctrl
// Description : Sole initiator of the single-port register file. Accepts one
//               READ1 / READ2 / WRITE request at a time over valid/ready,
//               sequences the port one access per cycle and returns the result
//               on a valid/ready response channel. All port outputs are
//               registered so the register file sees glitch-free controls.
//               Optional build macro REGFILE_R0_ZERO_EN hardwires register 0
//               to zero (writes suppressed, reads return 0).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              rst,         // asynchronous, active-low

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [SEL_W-1:0]  req_sel_a,
    input  logic [SEL_W-1:0]  req_sel_b,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic              rsp_err,

    output logic [SEL_W-1:0]  rf_RegSel,
    output logic              rf_WrReg,
    output logic [DATA_W-1:0] rf_Din,
    input  logic [DATA_W-1:0] rf_Dout
);

    state_t              r_state;
    logic [1:0]          r_op;
    logic [SEL_W-1:0]    r_sel_b;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_data_a;
    logic [DATA_W-1:0]   r_data_b;
    logic [SEL_W-1:0]    r_rf_sel;
    logic                r_rf_wr;
    logic [DATA_W-1:0]   r_rf_din;

    logic [DATA_W-1:0]   w_rd_data;    // read data as seen by the capture regs
    logic                w_wr_en;      // write strobe allowed for req_sel_a

`ifdef REGFILE_R0_ZERO_EN
    // Register 0 reads as zero and is never written. During RD_A/RD_B the
    // select register holds the address being read, so it qualifies the data.
    assign w_rd_data = (r_rf_sel == '0) ? '0 : rf_Dout;
    assign w_wr_en   = (req_sel_a != '0);
`else
    assign w_rd_data = rf_Dout;
    assign w_wr_en   = 1'b1;
`endif

    // Controller FSM: state, latched request, capture registers and
    // registered register-file port controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ1;
            r_sel_b     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_rf_sel    <= '0;
            r_rf_wr     <= 1'b0;
            r_rf_din    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // req_ready is high throughout IDLE, so valid alone accepts
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_sel_b     <= req_sel_b;
                        r_req_ready <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_data_b    <= '0;
                        case (req_op)
                            OP_READ1, OP_READ2: begin
                                r_state  <= ST_RD_A;
                                r_rf_sel <= req_sel_a;
                            end
                            OP_WRITE: begin
                                // Write data doubles as the response payload
                                r_state  <= ST_WR;
                                r_rf_sel <= req_sel_a;
                                r_rf_din <= req_wdata;
                                r_rf_wr  <= w_wr_en;
                                r_data_a <= req_wdata;
                            end
                            default: begin
                                // Reserved opcode: answer immediately, no access
                                r_state     <= ST_RSP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b1;
                                r_data_a    <= '0;
                            end
                        endcase
                    end
                end
                ST_RD_A: begin
                    r_data_a <= w_rd_data;
                    if (r_op == OP_READ2) begin
                        r_state  <= ST_RD_B;
                        r_rf_sel <= r_sel_b;
                    end else begin
                        r_state     <= ST_RSP;
                        r_rf_sel    <= '0;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_RD_B: begin
                    r_data_b    <= w_rd_data;
                    r_state     <= ST_RSP;
                    r_rf_sel    <= '0;
                    r_rsp_valid <= 1'b1;
                end
                ST_WR: begin
                    // Write commits at this edge; strobe lasts one cycle only
                    r_state     <= ST_RSP;
                    r_rf_sel    <= '0;
                    r_rf_wr     <= 1'b0;
                    r_rf_din    <= '0;
                    r_rsp_valid <= 1'b1;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rf_sel    <= '0;
                    r_rf_wr     <= 1'b0;
                    r_rf_din    <= '0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_data_a = r_data_a;
    assign rsp_data_b = r_data_b;
    assign rf_RegSel  = r_rf_sel;
    assign rf_WrReg   = r_rf_wr;
    assign rf_Din     = r_rf_din;

endmodule : regfile_access_ctrl
`default_nettype wire
